// File: rtl/rs.sv
// Reservation station for the integer ALU: holds issued instructions until both operands
// are ready, snoops ALU/LSB broadcasts, dispatches one per cycle. Option: RS_ISSUE_BYPASS_EN.
module rs #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 issue_en,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_func3,
    input  logic                 issue_func1,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic                 issue_rs1_rdy,
    input  logic [31:0]          issue_rs1_val,
    input  logic [ROB_POS_W-1:0] issue_rs1_tag,
    input  logic                 issue_rs2_rdy,
    input  logic [31:0]          issue_rs2_val,
    input  logic [ROB_POS_W-1:0] issue_rs2_tag,
    output logic                 rs_full,

    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [31:0]          alu_result_val,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [31:0]          lsb_result_val,

    output logic                 alu_en,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_func3,
    output logic                 alu_func1,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic                 rdy;
        logic [31:0]          val;
        logic [ROB_POS_W-1:0] tag;
    } operand_t;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic                 func1;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_POS_W-1:0] rob_pos;
        operand_t             op1;
        operand_t             op2;
    } entry_t;

    typedef struct packed {
        logic                 en;
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic                 func1;
        logic [31:0]          val1;
        logic [31:0]          val2;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } disp_t;

    logic [RS_SIZE-1:0] busy, busy_nxt;
    entry_t             ent     [RS_SIZE];
    entry_t             ent_nxt [RS_SIZE];
    disp_t              disp_q, disp_nxt;

    logic               free_found, sel_found, issue_ok;
    logic [IDX_W-1:0]   free_idx, sel_idx;
    operand_t           new_op1, new_op2;

    // Capture a broadcast value into an operand that is still waiting on its tag.
    function automatic operand_t wake(operand_t op);
        operand_t r = op;
        if (!op.rdy) begin
            if (alu_result && op.tag == alu_result_rob_pos) begin
                r.rdy = 1'b1;
                r.val = alu_result_val;
            end else if (lsb_result && op.tag == lsb_result_rob_pos) begin
                r.rdy = 1'b1;
                r.val = lsb_result_val;
            end
        end
        return r;
    endfunction

    assign rs_full  = &busy;
    assign issue_ok = issue_en && !rs_full;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!sel_found && busy[i] && ent[i].op1.rdy && ent[i].op2.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_ISSUE_BYPASS_EN
    assign new_op1 = wake({issue_rs1_rdy, issue_rs1_val, issue_rs1_tag});
    assign new_op2 = wake({issue_rs2_rdy, issue_rs2_val, issue_rs2_tag});
`else
    assign new_op1 = {issue_rs1_rdy, issue_rs1_val, issue_rs1_tag};
    assign new_op2 = {issue_rs2_rdy, issue_rs2_val, issue_rs2_tag};
`endif

    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_nxt[i] = ent[i];
            if (busy[i]) begin
                ent_nxt[i].op1 = wake(ent[i].op1);
                ent_nxt[i].op2 = wake(ent[i].op2);
            end
        end
        // The issue target is never busy, so it cannot collide with the dispatched entry.
        if (sel_found)
            busy_nxt[sel_idx] = 1'b0;
        if (issue_ok) begin
            busy_nxt[free_idx]        = 1'b1;
            ent_nxt[free_idx].opcode  = issue_opcode;
            ent_nxt[free_idx].func3   = issue_func3;
            ent_nxt[free_idx].func1   = issue_func1;
            ent_nxt[free_idx].imm     = issue_imm;
            ent_nxt[free_idx].pc      = issue_pc;
            ent_nxt[free_idx].rob_pos = issue_rob_pos;
            ent_nxt[free_idx].op1     = new_op1;
            ent_nxt[free_idx].op2     = new_op2;
        end
    end

    always_comb begin
        disp_nxt = '0;
        if (sel_found) begin
            disp_nxt.en      = 1'b1;
            disp_nxt.opcode  = ent[sel_idx].opcode;
            disp_nxt.func3   = ent[sel_idx].func3;
            disp_nxt.func1   = ent[sel_idx].func1;
            disp_nxt.val1    = ent[sel_idx].op1.val;
            disp_nxt.val2    = ent[sel_idx].op2.val;
            disp_nxt.imm     = ent[sel_idx].imm;
            disp_nxt.pc      = ent[sel_idx].pc;
            disp_nxt.rob_pos = ent[sel_idx].rob_pos;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= '0;
            disp_q <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy   <= '0;
                disp_q <= '0;
            end else begin
                busy   <= busy_nxt;
                disp_q <= disp_nxt;
            end
        end
    end

    // NOTE: entry payload is not reset; a clear busy bit makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (rdy && !rollback)
            ent <= ent_nxt;
    end

    assign alu_en      = disp_q.en;
    assign alu_opcode  = disp_q.opcode;
    assign alu_func3   = disp_q.func3;
    assign alu_func1   = disp_q.func1;
    assign alu_val1    = disp_q.val1;
    assign alu_val2    = disp_q.val2;
    assign alu_imm     = disp_q.imm;
    assign alu_pc      = disp_q.pc;
    assign alu_rob_pos = disp_q.rob_pos;

endmodule

// File: tb/tb_rs.sv
// Directed self-checking bench for the ALU reservation station.
module tb_rs;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        issue_en;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_func3;
    logic        issue_func1;
    logic [31:0] issue_imm, issue_pc;
    logic [3:0]  issue_rob_pos;
    logic        issue_rs1_rdy, issue_rs2_rdy;
    logic [31:0] issue_rs1_val, issue_rs2_val;
    logic [3:0]  issue_rs1_tag, issue_rs2_tag;
    logic        rs_full;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_func1;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;

    rs #(.RS_SIZE(16), .ROB_POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_en(issue_en), .issue_opcode(issue_opcode), .issue_func3(issue_func3),
        .issue_func1(issue_func1), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_pos(issue_rob_pos),
        .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_val(issue_rs1_val), .issue_rs1_tag(issue_rs1_tag),
        .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_val(issue_rs2_val), .issue_rs2_tag(issue_rs2_tag),
        .rs_full(rs_full),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func1(alu_func1),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        issue_en = 0; issue_opcode = 0; issue_func3 = 0; issue_func1 = 0;
        issue_imm = 0; issue_pc = 0; issue_rob_pos = 0;
        issue_rs1_rdy = 1; issue_rs1_val = 0; issue_rs1_tag = 0;
        issue_rs2_rdy = 1; issue_rs2_val = 0; issue_rs2_tag = 0;
        alu_result = 0; alu_result_rob_pos = 0; alu_result_val = 0;
        lsb_result = 0; lsb_result_rob_pos = 0; lsb_result_val = 0;
    endtask

    task automatic drive_issue(input logic [6:0] op, input logic [31:0] imm, input logic [31:0] pc,
                               input logic [3:0] rob, input logic r1, input logic [31:0] v1,
                               input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                               input logic [3:0] t2);
        issue_en = 1; issue_opcode = op; issue_func3 = 3'd0; issue_func1 = 1'b0;
        issue_imm = imm; issue_pc = pc; issue_rob_pos = rob;
        issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_tag = t1;
        issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_tag = t2;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; rollback = 0;
        clear_inputs();
        step(2);
        total++;
        if ({alu_en, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos, alu_opcode} !== '0) begin
            bad++; $display("FAIL reset_outputs: got en=%0b val1=%h pc=%h want all zero", alu_en, alu_val1, alu_pc);
        end
        total++;
        if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", rs_full); end
        rst = 0;
        step(1);
    endtask

    task automatic test_addi();
        drive_issue(OP_ARITHI, 32'd3, 32'h100, 4'd4, 1, 32'd5, 0, 1, 0, 0);
        issue_func3 = 3'd0;
        step(1);
        clear_inputs();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL addi_early: got en=%0b want 0", alu_en); end
        step(1);
        total++;
        if (alu_en !== 1'b1 || alu_val1 !== 32'd5 || alu_imm !== 32'd3 || alu_rob_pos !== 4'd4 ||
            alu_opcode !== OP_ARITHI || alu_pc !== 32'h100) begin
            bad++; $display("FAIL addi_dispatch: got en=%0b val1=%0d imm=%0d rob=%0d pc=%h want 1 5 3 4 100",
                            alu_en, alu_val1, alu_imm, alu_rob_pos, alu_pc);
        end
        step(1);
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL addi_pulse: got en=%0b want 0", alu_en); end
    endtask

    task automatic test_wakeup();
        drive_issue(OP_ARITH, 0, 32'h200, 4'd1, 1, 32'h22, 0, 0, 0, 4'd7);
        step(1);
        clear_inputs();
        step(2);
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_wait: got en=%0b want 0", alu_en); end
        alu_result = 1; alu_result_rob_pos = 4'd7; alu_result_val = 32'h10;
        step(1);
        clear_inputs();
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL wake_early: got en=%0b want 0", alu_en); end
        step(1);
        total++;
        if (alu_en !== 1'b1 || alu_val2 !== 32'h10 || alu_val1 !== 32'h22 || alu_rob_pos !== 4'd1) begin
            bad++; $display("FAIL wake_dispatch: got en=%0b val1=%h val2=%h rob=%0d want 1 22 10 1",
                            alu_en, alu_val1, alu_val2, alu_rob_pos);
        end
        step(1);
    endtask

    task automatic test_dual_bus();
        drive_issue(OP_ARITH, 0, 32'h300, 4'd6, 0, 0, 4'd1, 0, 0, 4'd2);
        step(1);
        clear_inputs();
        alu_result = 1; alu_result_rob_pos = 4'd1; alu_result_val = 32'hA;
        lsb_result = 1; lsb_result_rob_pos = 4'd2; lsb_result_val = 32'hB;
        step(1);
        clear_inputs();
        step(1);
        total++;
        if (alu_en !== 1'b1 || alu_val1 !== 32'hA || alu_val2 !== 32'hB) begin
            bad++; $display("FAIL dual_bus: got en=%0b val1=%h val2=%h want 1 a b", alu_en, alu_val1, alu_val2);
        end
        step(1);
    endtask

    task automatic test_back_to_back();
        drive_issue(OP_ARITHI, 32'd1, 0, 4'd8, 1, 32'd11, 0, 1, 0, 0);
        step(1);
        drive_issue(OP_ARITHI, 32'd2, 0, 4'd9, 1, 32'd12, 0, 1, 0, 0);
        step(1);
        clear_inputs();
        total++;
        if (alu_en !== 1'b1 || alu_rob_pos !== 4'd8 || alu_val1 !== 32'd11) begin
            bad++; $display("FAIL b2b_first: got en=%0b rob=%0d val1=%0d want 1 8 11", alu_en, alu_rob_pos, alu_val1);
        end
        step(1);
        total++;
        if (alu_en !== 1'b1 || alu_rob_pos !== 4'd9 || alu_val1 !== 32'd12) begin
            bad++; $display("FAIL b2b_second: got en=%0b rob=%0d val1=%0d want 1 9 12", alu_en, alu_rob_pos, alu_val1);
        end
        step(1);
    endtask

    task automatic test_fill();
        int early = 0;
        for (int i = 0; i < 16; i++) begin
            drive_issue(OP_ARITH, 0, 32'h1000 + i, 4'(i), 0, 0, 4'd3, 1, 32'(i), 0);
            step(1);
            if (alu_en !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("FAIL fill_no_dispatch: got %0d pulses want 0", early); end
        total++;
        if (rs_full !== 1'b1) begin bad++; $display("FAIL fill_full: got %0b want 1", rs_full); end
        // Issue while full must be ignored.
        drive_issue(OP_ARITHI, 0, 32'hDEAD, 4'd9, 1, 32'h99, 0, 1, 0, 0);
        step(1);
        clear_inputs();
        alu_result = 1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h33;
        step(1);
        clear_inputs();
        total++;
        if (alu_en !== 1'b0 || rs_full !== 1'b1) begin
            bad++; $display("FAIL fill_wake_early: got en=%0b full=%0b want 0 1", alu_en, rs_full);
        end
        for (int i = 0; i < 16; i++) begin
            step(1);
            total++;
            if (alu_en !== 1'b1 || alu_rob_pos !== 4'(i) || alu_val1 !== 32'h33 ||
                alu_val2 !== 32'(i) || alu_pc !== 32'h1000 + i) begin
                bad++; $display("FAIL fill_order[%0d]: got en=%0b rob=%0d val1=%h val2=%h pc=%h want 1 %0d 33 %h %h",
                                i, alu_en, alu_rob_pos, alu_val1, alu_val2, alu_pc, i, i, 32'h1000 + i);
            end
        end
        step(1);
        total++;
        if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
            bad++; $display("FAIL fill_drained: got en=%0b full=%0b want 0 0", alu_en, rs_full);
        end
    endtask

    task automatic test_bypass();
        drive_issue(OP_ARITHI, 32'd4, 0, 4'd5, 0, 0, 4'd2, 1, 0, 0);
        lsb_result = 1; lsb_result_rob_pos = 4'd2; lsb_result_val = 32'd9;
        step(1);
        clear_inputs();
`ifdef RS_ISSUE_BYPASS_EN
        step(1);
        total++;
        if (alu_en !== 1'b1 || alu_val1 !== 32'd9 || alu_rob_pos !== 4'd5) begin
            bad++; $display("FAIL bypass_dispatch: got en=%0b val1=%0d rob=%0d want 1 9 5", alu_en, alu_val1, alu_rob_pos);
        end
`else
        step(2);
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL nobypass_wait: got en=%0b want 0", alu_en); end
        lsb_result = 1; lsb_result_rob_pos = 4'd2; lsb_result_val = 32'd9;
        step(1);
        clear_inputs();
        step(1);
        total++;
        if (alu_en !== 1'b1 || alu_val1 !== 32'd9 || alu_rob_pos !== 4'd5) begin
            bad++; $display("FAIL nobypass_dispatch: got en=%0b val1=%0d rob=%0d want 1 9 5", alu_en, alu_val1, alu_rob_pos);
        end
`endif
        step(1);
    endtask

    task automatic test_rollback();
        int stray = 0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(OP_ARITH, 0, 0, 4'(10 + i), 0, 0, 4'd5, 1, 0, 0);
            step(1);
        end
        drive_issue(OP_ARITHI, 0, 0, 4'd14, 1, 32'd1, 0, 1, 0, 0);
        step(1);
        clear_inputs();
        rollback = 1;
        drive_issue(OP_ARITHI, 0, 0, 4'd15, 1, 32'd2, 0, 1, 0, 0);
        step(1);
        rollback = 0;
        clear_inputs();
        total++;
        if (alu_en !== 1'b0 || alu_rob_pos !== 4'd0 || rs_full !== 1'b0) begin
            bad++; $display("FAIL rollback_clear: got en=%0b rob=%0d full=%0b want 0 0 0", alu_en, alu_rob_pos, rs_full);
        end
        alu_result = 1; alu_result_rob_pos = 4'd5; alu_result_val = 32'h55;
        step(1);
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            if (alu_en !== 1'b0) stray++;
            step(1);
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL rollback_stale: got %0d pulses want 0", stray); end
    endtask

    task automatic test_stall();
        drive_issue(OP_ARITHI, 32'd7, 0, 4'd3, 1, 32'd8, 0, 1, 0, 0);
        step(1);
        clear_inputs();
        rdy = 0;
        step(2);
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL stall_frozen: got en=%0b want 0", alu_en); end
        rdy = 1;
        step(1);
        rdy = 0;
        step(2);
        total++;
        if (alu_en !== 1'b1 || alu_rob_pos !== 4'd3 || alu_val1 !== 32'd8) begin
            bad++; $display("FAIL stall_hold: got en=%0b rob=%0d val1=%0d want 1 3 8", alu_en, alu_rob_pos, alu_val1);
        end
        rdy = 1;
        step(1);
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL stall_release: got en=%0b want 0", alu_en); end
    endtask

    task automatic test_async_reset();
        drive_issue(OP_ARITHI, 32'd1, 32'h44, 4'd2, 1, 32'd6, 0, 1, 0, 0);
        drive_issue(OP_ARITHI, 32'd1, 32'h44, 4'd2, 1, 32'd6, 0, 1, 0, 0);
        step(1);
        drive_issue(OP_ARITHI, 32'd1, 32'h48, 4'd3, 0, 0, 4'd12, 1, 0, 0);
        step(1);
        clear_inputs();
        total++;
        if (alu_en !== 1'b1 || alu_pc !== 32'h44) begin
            bad++; $display("FAIL areset_pre: got en=%0b pc=%h want 1 44", alu_en, alu_pc);
        end
        #2 rst = 1;
        #1;
        total++;
        if ({alu_en, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos, alu_opcode, alu_func3, alu_func1} !== '0 ||
            rs_full !== 1'b0) begin
            bad++; $display("FAIL areset_immediate: got en=%0b val1=%h pc=%h full=%0b want all zero",
                            alu_en, alu_val1, alu_pc, rs_full);
        end
        step(1);
        rst = 0;
        alu_result = 1; alu_result_rob_pos = 4'd12; alu_result_val = 32'h1;
        step(1);
        clear_inputs();
        step(2);
        total++;
        if (alu_en !== 1'b0) begin bad++; $display("FAIL areset_stale: got en=%0b want 0", alu_en); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_wakeup();
        test_dual_bus();
        test_back_to_back();
        test_fill();
        test_bypass();
        test_rollback();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs.md
# rs

Reservation station for the integer ALU in the out-of-order RISC-V core. Accepts decoded ALU/branch/jump/LUI/AUIPC instructions from the issue stage, holds them until both source operands are available, and dispatches one ready instruction per cycle to the ALU. It snoops the ALU and load/store result broadcasts to wake waiting operands. It is the initiator of the ALU dispatch interface (`alu_en` plus operand bundle) and a consumer of the ALU result broadcast.

## Interface
- `RS_SIZE`, 16: number of entries, power of two, 2..32.
- `ROB_POS_W`, 4: ROB tag width; must match `ROB_POS_WID`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable; low freezes all state and outputs.
- `rollback` in 1: misprediction flush.
- `issue_en` in 1: new instruction present this cycle.
- `issue_opcode` in 7, `issue_func3` in 3, `issue_func1` in 1: instruction fields.
- `issue_imm` in 32, `issue_pc` in 32, `issue_rob_pos` in ROB_POS_W: immediate (pre-extended), PC, destination tag.
- `issue_rs1_rdy` in 1, `issue_rs1_val` in 32, `issue_rs1_tag` in ROB_POS_W: operand 1 (value valid if rdy, else tag).
- `issue_rs2_rdy` in 1, `issue_rs2_val` in 32, `issue_rs2_tag` in ROB_POS_W: operand 2.
- `rs_full` out 1: no free entry.
- `alu_result` in 1, `alu_result_rob_pos` in ROB_POS_W, `alu_result_val` in 32: ALU broadcast.
- `lsb_result` in 1, `lsb_result_rob_pos` in ROB_POS_W, `lsb_result_val` in 32: load/store broadcast.
- `alu_en` out 1, `alu_opcode` out 7, `alu_func3` out 3, `alu_func1` out 1: dispatch strobe and fields.
- `alu_val1` out 32, `alu_val2` out 32, `alu_imm` out 32, `alu_pc` out 32, `alu_rob_pos` out ROB_POS_W: dispatch operands.

## Operation
- Per entry: busy, opcode, func3, func1, imm, pc, rob_pos, and for each operand a ready flag, value, and tag.
- Operands not used by an opcode (rs2 for ARITHI/LUI/AUIPC/JAL/JALR, rs1 for LUI/AUIPC/JAL) arrive with rdy=1 from issue. The RS does not decode usage.
- Insert: on `issue_en`, write into the lowest-index non-busy entry and set busy. The issuer never asserts `issue_en` while `rs_full`=1. The RS ignores such an issue and does not corrupt any entry.
- Wakeup: for every busy entry and each operand with ready=0, a tag match with `alu_result_rob_pos` (when `alu_result`) or `lsb_result_rob_pos` (when `lsb_result`) captures the value and sets ready. Both buses can wake different operands in the same cycle.
- Select: the lowest-index busy entry with both operands ready is dispatched. Its busy bit clears at the same edge.
- Insert and dispatch may target different entries in the same cycle. A freed entry is reusable from the following cycle.
- `rs_full` is combinational: all entries busy. It ignores any same-cycle dispatch.

## Timing
- Reset or rollback: all busy bits clear. `alu_en`=0 and all `alu_*` outputs are 0. `rs_full`=0.
- Rollback is synchronous at the clock edge, takes priority over issue, wakeup and dispatch, and discards any same-cycle issue.
- Dispatch outputs are registered. An entry that is ready at edge N drives `alu_en`=1 for exactly the cycle after edge N. `alu_en` is a one-cycle pulse per instruction.
- Wakeup latency: a broadcast in cycle C makes the entry eligible for selection in cycle C+1, so `alu_en` goes high after edge C+1.
- An entry issued with both operands ready in cycle C dispatches at the earliest after edge C+1.
- `rdy`=0 holds every register, including `alu_en`.

## Configuration
- `RS_ISSUE_BYPASS_EN` defined: on the issue cycle, an operand with rdy=0 whose tag matches a same-cycle `alu_result` or `lsb_result` broadcast is written as ready with the broadcast value.
- `RS_ISSUE_BYPASS_EN` undefined: the incoming operand stores its tag only. The ROB/issue stage guarantees same-cycle broadcasts are already forwarded into `issue_rsX_val` and `issue_rsX_rdy`.

## Test plan
- Issue ADDI, rs1 ready val=5, imm=3 -> `alu_en`=1 one cycle later, `alu_val1`=5, `alu_imm`=3, `alu_rob_pos` equals the issued tag.
- Issue ADD with rs2 tag=7 not ready, then `alu_result` tag=7 val=0x10 -> dispatch the next cycle with `alu_val2`=0x10, never earlier.
- Fill all 16 entries with operands waiting on tag 3 -> `rs_full`=1. Broadcast tag 3 -> entries dispatch lowest index first, one per cycle, 16 consecutive `alu_en` pulses.
- Issue with rs1 tag=2 in the same cycle `lsb_result` tag=2 val=9 -> with the macro defined, dispatch next cycle with `alu_val1`=9.
- Rollback while 5 entries are busy and a dispatch is pending -> `alu_en`=0 the next cycle, `rs_full`=0, no later dispatch from old entries.
- Assert `rst` asynchronously mid-dispatch -> all outputs are 0 immediately, without waiting for a clock edge.
